// File: rtl/dm_copy_if.sv
// Control and data-memory signals of the copy engine, bundled for port use.
// master = engine side, slave = environment side (CPU control + DM model).
interface dm_copy_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
);
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_writedata;
  logic          dm_we;
  logic [DW-1:0] dm_readdata;

  modport master (
    input  start, src, dst, len, dm_readdata,
    output busy, done, dm_addr, dm_writedata, dm_we
  );

  modport slave (
    output start, src, dst, len, dm_readdata,
    input  busy, done, dm_addr, dm_writedata, dm_we
  );
endinterface

// File: rtl/dm_copy_engine.sv
// Block copy engine for the single-port DM: one read cycle then one write
// cycle per word, direction chosen at start so overlapping copies are safe.
module dm_copy_engine #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic     clk,
  input  logic     reset,
  dm_copy_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Overlap test is done wide enough that src+len never wraps.
  localparam int SW = ((AW > LW) ? AW : LW) + 1;
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [LW-1:0] ONE_L = LW'(1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] dp_q, dp_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          desc_q, desc_d;

  logic [SW-1:0] src_w, dst_w, end_w;
  logic [AW-1:0] len_a;
  logic          desc_start;

  assign src_w      = SW'(bus.src);
  assign dst_w      = SW'(bus.dst);
  assign end_w      = src_w + SW'(bus.len);
  assign desc_start = (dst_w > src_w) && (dst_w < end_w);
  assign len_a      = AW'(bus.len);

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    dp_d    = dp_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    desc_d  = desc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          desc_d  = desc_start;
          sp_d    = desc_start ? (bus.src + len_a - ONE_A) : bus.src;
          dp_d    = desc_start ? (bus.dst + len_a - ONE_A) : bus.dst;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        data_d  = bus.dm_readdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        sp_d    = desc_q ? (sp_q - ONE_A) : (sp_q + ONE_A);
        dp_d    = desc_q ? (dp_q - ONE_A) : (dp_q + ONE_A);
        cnt_d   = cnt_q - ONE_L;
        state_d = (cnt_q == ONE_L) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      dp_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      desc_q  <= desc_d;
    end
  end

  // Outputs decode from state and registers only, so reset clears them at once.
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.dm_we        = (state_q == S_WRITE);
  assign bus.dm_writedata = (state_q == S_WRITE) ? data_q : '0;
  assign bus.dm_addr      = (state_q == S_READ)  ? sp_q :
                            (state_q == S_WRITE) ? dp_q : '0;
endmodule

// File: tb/tb_dm_copy_engine.sv
// Randomised bench for dm_copy_engine with a memmove-style reference model
// and a per-cycle expected-output queue; AW reduced to 8 for wrap coverage.
module tb_dm_copy_engine;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_copy_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
  dm_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] mem [256];
  logic [DW-1:0] model_mem [256];
  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [DW-1:0] pk_data = '0;

  assign bus.dm_readdata = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_writedata;
    else if (pk_en) mem[pk_addr] <= pk_data;
  end

  int errors = 0, checks = 0;
  int cyc = 0, done_cyc = 0, done_cnt = 0, busy_cyc = 0, a0 = 0;
  int wr_log[$];
  exp_t exp_q[$];
  exp_t pend[$];
  bit chk_idle = 1'b0;

  function automatic exp_t mk(logic b, logic dn, logic w, logic [AW-1:0] a, logic [DW-1:0] wd);
    exp_t e;
    e.busy = b; e.done = dn; e.we = w; e.addr = a; e.wd = wd;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Bus activity monitor: values seen here are those of the cycle just ending.
  always @(posedge clk) begin
    if (bus.done) begin done_cyc = cyc; done_cnt++; end
    if (bus.busy) busy_cyc++;
    if (bus.dm_we) wr_log.push_back(int'(bus.dm_addr));
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    exp_t a, e;
    a = mk(bus.busy, bus.done, bus.dm_we, bus.dm_addr, bus.dm_writedata);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", 64'(a), 64'(e));
    end else if (chk_idle) begin
      chk("idle", 64'(a), 64'(mk(0, 0, 0, '0, '0)));
    end
  end

  // Reference: element-by-element copy in the chosen order (memmove semantics).
  task automatic gen(input int s, input int d, input int l, input int limit);
    bit desc;
    int idx;
    logic [AW-1:0] sa, da;
    logic [DW-1:0] v;
    pend.delete();
    desc = (d > s) && (d < s + l);
    for (int i = 0; i < l; i++) begin
      idx = desc ? (l - 1 - i) : i;
      sa  = AW'((s + idx) % 256);
      da  = AW'((d + idx) % 256);
      v   = model_mem[sa];
      if (i < limit) model_mem[da] = v;
      pend.push_back(mk(1, 0, 0, sa, '0));
      pend.push_back(mk(1, 0, 1, da, v));
    end
    pend.push_back(mk(1, 1, 0, '0, '0));
  endtask

  task automatic poke(input int a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    pk_en = 1'b1; pk_addr = AW'(a); pk_data = v;
    @(posedge clk); #1;
    pk_en = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic start_copy(input int s, input int d, input int l);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src = AW'(s); bus.dst = AW'(d); bus.len = LW'(l);
    wr_log.delete(); busy_cyc = 0; done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    a0 = cyc;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  task automatic copy(input int s, input int d, input int l);
    start_copy(s, d, l);
    gen(s, d, l, l);
    while (pend.size() > 0) exp_q.push_back(pend.pop_front());
    drain();
  endtask

  initial begin
    int s, d, l;
    bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    #1;
    chk("reset_outputs", 64'(mk(bus.busy, bus.done, bus.dm_we, bus.dm_addr, bus.dm_writedata)), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_idle = 1'b1;
    for (int i = 0; i < 256; i++) poke(i, $urandom);

    // Basic 3-word copy
    poke(8, 2); poke(9, 3); poke(10, 4);
    copy(8, 20, 3);
    chk("t1_nwr", 64'(wr_log.size()), 64'd3);
    chk("t1_wa0", 64'(wr_log[0]), 64'd20);
    chk("t1_wa1", 64'(wr_log[1]), 64'd21);
    chk("t1_wa2", 64'(wr_log[2]), 64'd22);
    chk("t1_mem", 64'({mem[20][7:0], mem[21][7:0], mem[22][7:0]}), 64'h020304);
    chk("t1_done_cyc", 64'(done_cyc - a0 + 1), 64'd7);
    chk("t1_busy_cyc", 64'(busy_cyc), 64'd7);
    check_mem("t1_model");

    // len = 0
    copy(5, 100, 0);
    chk("t2_nwr", 64'(wr_log.size()), 64'd0);
    chk("t2_done_cyc", 64'(done_cyc - a0 + 1), 64'd1);
    chk("t2_busy_cyc", 64'(busy_cyc), 64'd1);
    check_mem("t2_model");

    // Overlap, dst above src: descending
    poke(8, 1); poke(9, 2); poke(10, 3); poke(11, 4);
    copy(8, 9, 4);
    chk("t3_wa", 64'({wr_log[0][7:0], wr_log[1][7:0], wr_log[2][7:0], wr_log[3][7:0]}), 64'h0c0b0a09);
    chk("t3_mem", 64'({mem[8][7:0], mem[9][7:0], mem[10][7:0], mem[11][7:0], mem[12][7:0]}), 64'h0101020304);
    check_mem("t3_model");

    // Overlap, dst below src: ascending (mem[12] is 4 from above)
    poke(8, 1); poke(9, 2); poke(10, 3); poke(11, 4);
    copy(9, 8, 4);
    chk("t4_wa", 64'({wr_log[0][7:0], wr_log[1][7:0], wr_log[2][7:0], wr_log[3][7:0]}), 64'h08090a0b);
    chk("t4_mem", 64'({mem[8][7:0], mem[9][7:0], mem[10][7:0], mem[11][7:0], mem[12][7:0]}), 64'h0203040404);
    check_mem("t4_model");

    // start re-pulsed while busy must be ignored
    start_copy(30, 50, 4);
    gen(30, 50, 4, 4);
    while (pend.size() > 0) exp_q.push_back(pend.pop_front());
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src = AW'(0); bus.dst = AW'(1); bus.len = LW'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();
    chk("t5_busy_cyc", 64'(busy_cyc), 64'd9);
    chk("t5_done_cyc", 64'(done_cyc - a0 + 1), 64'd9);
    check_mem("t5_model");

    // Reset during WRITE of word 1
    start_copy(40, 60, 3);
    gen(40, 60, 3, 1);
    for (int i = 0; i < 3; i++) exp_q.push_back(pend[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_we_before", 64'({bus.dm_we, bus.dm_addr}), 64'({1'b1, 8'd61}));
    reset = 1'b0;
    #1;
    chk("t6_async", 64'({bus.dm_we, bus.busy, bus.done}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("t6_nwr", 64'(wr_log.size()), 64'd1);
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    check_mem("t6_model");
    copy(70, 90, 3);
    check_mem("t6_restart");

    // Wrap across the top of the address space
    poke(0, 32'hAA); poke(1, 32'hBB);
    copy(0, 255, 2);
    chk("t7_wa", 64'({wr_log[0][7:0], wr_log[1][7:0]}), 64'hff00);
    chk("t7_mem", 64'({mem[255][7:0], mem[0][7:0]}), 64'haabb);
    check_mem("t7_model");

    // Random copies, biased toward overlap
    for (int n = 0; n < 30; n++) begin
      s = $urandom_range(0, 255);
      if (n % 2 == 0) d = (s + $urandom_range(0, 8) + 252) % 256;
      else d = $urandom_range(0, 255);
      l = $urandom_range(0, 12);
      copy(s, d, l);
      check_mem("rand_mem");
      chk("rand_busy", 64'(busy_cyc), 64'(2 * l + 1));
    end

    chk_idle = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
